// File: rtl/tick_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tick_sequencer
// Purpose  : Prescaled tick burst generator (IDLE/RUN/DONE) with abort.
//            Optional clk_sq output enabled by macro TICK_SQUARE_OUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tick_sequencer #(
    parameter int DIV_W     = 26,
    parameter int CNT_W     = 16,
    parameter int DIV_RESET = 256
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DIV_W-1:0] div_val,
    input  logic             div_ld,
    input  logic [CNT_W-1:0] burst_len,
    input  logic             start,
    input  logic             stop,
    output logic             tick,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] tick_cnt
`ifdef TICK_SQUARE_OUT_EN
    ,
    output logic             clk_sq
`endif
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    localparam logic [DIV_W-1:0] c_DIV_RST = (DIV_RESET == 0) ? DIV_W'(1) : DIV_W'(DIV_RESET);

    logic [1:0]       r_state;
    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] r_presc;
    logic [CNT_W-1:0] r_len;

    logic [DIV_W-1:0] w_div_eff;
    logic             w_wrap;
    logic             w_tick_issue;
    logic [CNT_W-1:0] w_cnt_next;

    assign w_div_eff    = (div_val == '0) ? DIV_W'(1) : div_val;
    assign w_wrap       = (r_presc == (r_div - DIV_W'(1)));
    // stop wins over a tick falling due in the same cycle
    assign w_tick_issue = (r_state == c_RUN) && !stop && w_wrap;
    assign w_cnt_next   = tick_cnt + CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= c_IDLE;
            r_div    <= c_DIV_RST;
            r_presc  <= '0;
            r_len    <= '0;
            tick     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            tick_cnt <= '0;
        end else begin
            // done trails the DONE state by one cycle so it follows the final tick
            done <= (r_state == c_DONE);
            case (r_state)
                c_IDLE: begin
                    tick <= 1'b0;
                    if (div_ld) begin
                        r_div <= w_div_eff;
                    end
                    if (start) begin
                        r_len    <= burst_len;
                        r_presc  <= '0;
                        tick_cnt <= '0;
                        if (burst_len == '0) begin
                            r_state <= c_DONE;
                            busy    <= 1'b0;
                        end else begin
                            r_state <= c_RUN;
                            busy    <= 1'b1;
                        end
                    end
                end
                c_RUN: begin
                    if (stop) begin
                        r_state <= c_IDLE;
                        busy    <= 1'b0;
                        tick    <= 1'b0;
                    end else if (w_wrap) begin
                        r_presc  <= '0;
                        tick     <= 1'b1;
                        tick_cnt <= w_cnt_next;
                        if (w_cnt_next == r_len) begin
                            r_state <= c_DONE;
                            busy    <= 1'b0;
                        end
                    end else begin
                        r_presc <= r_presc + DIV_W'(1);
                        tick    <= 1'b0;
                    end
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                    tick    <= 1'b0;
                    busy    <= 1'b0;
                end
                default: begin
                    r_state <= c_IDLE;
                    tick    <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

`ifdef TICK_SQUARE_OUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sq <= 1'b0;
        end else if (w_tick_issue) begin
            clk_sq <= ~clk_sq;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_tick_sequencer.sv
`default_nettype none
// Randomised scoreboard bench for tick_sequencer: expected tick/done events and
// busy lengths are queued at stimulus time and consumed by a negedge monitor.
module tb_tick_sequencer;

    localparam int DIV_W = 26;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [DIV_W-1:0] div_val = '0;
    logic             div_ld = 1'b0;
    logic [CNT_W-1:0] burst_len = '0;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic             tick;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] tick_cnt;
`ifdef TICK_SQUARE_OUT_EN
    logic             clk_sq;
`endif

    tick_sequencer #(.DIV_W(DIV_W), .CNT_W(CNT_W), .DIV_RESET(256)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .div_val   (div_val),
        .div_ld    (div_ld),
        .burst_len (burst_len),
        .start     (start),
        .stop      (stop),
        .tick      (tick),
        .busy      (busy),
        .done      (done),
        .tick_cnt  (tick_cnt)
`ifdef TICK_SQUARE_OUT_EN
        ,
        .clk_sq    (clk_sq)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        is_done;
        logic [31:0] e;
        logic [31:0] c;
    } ev_t;

    ev_t exp_q[$];
    int  busy_q[$];
    int  total = 0;
    int  bad = 0;
    int  ecnt = 0;
    int  m_div = 256;
    int  busy_run = 0;
    int  sq_rises = 0;

    always @(posedge clk) ecnt <= ecnt + 1;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic check_ev(input bit d);
        ev_t x;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_%s: edge=%0d tick_cnt=%0d required no event",
                     d ? "done" : "tick", ecnt, tick_cnt);
        end else begin
            x = exp_q.pop_front();
            if (x.is_done !== d || int'(x.e) != ecnt || int'(x.c) != int'(tick_cnt)) begin
                bad++;
                $display("FAIL event: got %s edge=%0d cnt=%0d required %s edge=%0d cnt=%0d",
                         d ? "done" : "tick", ecnt, tick_cnt,
                         x.is_done ? "done" : "tick", x.e, x.c);
            end
        end
    endtask

    // monitor: sample between edges, consume the scoreboard
    always @(negedge clk) begin
        if (tick) check_ev(1'b0);
        if (done) check_ev(1'b1);
        if (busy) begin
            busy_run++;
        end else if (busy_run > 0) begin
            total++;
            if (busy_q.size() == 0) begin
                bad++;
                $display("FAIL busy_len: got %0d cycles required none", busy_run);
            end else begin
                int want;
                want = busy_q.pop_front();
                if (want != busy_run) begin
                    bad++;
                    $display("FAIL busy_len: got %0d required %0d", busy_run, want);
                end
            end
            busy_run = 0;
        end
    end

`ifdef TICK_SQUARE_OUT_EN
    logic sq_prev = 1'b0;
    always @(negedge clk) begin
        if (clk_sq && !sq_prev) sq_rises++;
        sq_prev = clk_sq;
    end
`endif

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push_ev(input bit d, input int e, input int c);
        ev_t x;
        x.is_done = d;
        x.e = 32'(e);
        x.c = 32'(c);
        exp_q.push_back(x);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_tick", int'(tick), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_tick_cnt", int'(tick_cnt), 0);
`ifdef TICK_SQUARE_OUT_EN
        chk("rst_clk_sq", int'(clk_sq), 0);
`endif
        m_div = 256;
        step();
        rst_n = 1'b1;
        step();
    endtask

    // One burst. stop_tick>0 asserts stop on the edge that tick is due.
    task automatic run(input int len, input bit ld, input int dv, input int stop_tick, input bit noise);
        int e0, d, es, last, n;
        start = 1'b1;
        burst_len = CNT_W'(len);
        div_ld = ld;
        div_val = DIV_W'(dv);
        if (ld) m_div = (dv == 0) ? 1 : dv;
        d  = m_div;
        e0 = ecnt + 1;
        es = (stop_tick > 0) ? e0 + stop_tick * d : 0;
        n  = 0;
        if (len == 0) begin
            push_ev(1'b1, e0 + 1, 0);
            last = e0 + 1;
        end else begin
            for (int i = 1; i <= len; i++) begin
                if (es == 0 || e0 + i * d < es) begin
                    n = i;
                    push_ev(1'b0, e0 + i * d, i);
                end
            end
            if (es == 0) begin
                push_ev(1'b1, e0 + len * d + 1, len);
                busy_q.push_back(len * d);
                last = e0 + len * d + 1;
            end else begin
                busy_q.push_back(es - e0);
                last = es;
            end
        end
        step();
        start = 1'b0;
        div_ld = 1'b0;
        div_val = '0;
        if (noise) begin
            step();
            start = 1'b1;
            burst_len = CNT_W'(1);
            div_ld = 1'b1;
            div_val = DIV_W'(3);
            step();
            start = 1'b0;
            div_ld = 1'b0;
        end
        if (es > 0) begin
            while (ecnt < es - 1) step();
            stop = 1'b1;
            step();
            stop = 1'b0;
        end
        while (ecnt < last + 1) step();
        chk("events_drained", exp_q.size(), 0);
        chk("busy_drained", busy_q.size(), 0);
        chk("tick_cnt_final", int'(tick_cnt), (es == 0) ? len : n);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

    initial begin
        int e0, len, dv, d, st, gap;
        bit ld, nz;
        repeat (3) step();
        do_reset();

        run(3, 1'b0, 0, 0, 1'b0);
        step(); step();
        chk("tick_cnt_hold", int'(tick_cnt), 3);

        run(5, 1'b1, 4, 0, 1'b0);
        run(4, 1'b1, 0, 0, 1'b0);
        run(0, 1'b0, 0, 0, 1'b0);
        run(10, 1'b1, 8, 3, 1'b1);

        // reset in the middle of a div=8 burst
        start = 1'b1;
        burst_len = CNT_W'(10);
        div_ld = 1'b1;
        div_val = DIV_W'(8);
        m_div = 8;
        e0 = ecnt + 1;
        push_ev(1'b0, e0 + 8, 1);
        push_ev(1'b0, e0 + 16, 2);
        busy_q.push_back(20);
        step();
        start = 1'b0;
        div_ld = 1'b0;
        while (ecnt < e0 + 20) step();
        do_reset();
        step();
        chk("events_after_reset", exp_q.size(), 0);
        run(1, 1'b0, 0, 0, 1'b0);

`ifdef TICK_SQUARE_OUT_EN
        do_reset();
        sq_rises = 0;
        run(4, 1'b1, 2, 0, 1'b0);
        chk("clk_sq_periods", sq_rises, 2);
        chk("clk_sq_end", int'(clk_sq), 0);
        run(3, 1'b1, 2, 0, 1'b0);
        chk("clk_sq_odd", int'(clk_sq), 1);
        do_reset();
`endif

        for (int r = 0; r < 40; r++) begin
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                stop = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 3) == 0) begin
                    div_ld = 1'b1;
                    dv = $urandom_range(0, 6);
                    div_val = DIV_W'(dv);
                    m_div = (dv == 0) ? 1 : dv;
                end
                step();
                stop = 1'b0;
                div_ld = 1'b0;
            end
            ld  = (r == 0) || ($urandom_range(0, 3) != 0);
            dv  = $urandom_range(0, 6);
            len = $urandom_range(0, 6);
            d   = ld ? ((dv == 0) ? 1 : dv) : m_div;
            st  = (len > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(1, len) : 0;
            nz  = (len * d > 3) && (st == 0 || st * d >= 3) && ($urandom_range(0, 1) == 1);
            run(len, ld, dv, st, nz);
        end

        repeat (3) step();
        chk("final_events_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tick_sequencer.md
TICK_SEQUENCER -- requirements
Module: tick_sequencer

Interface
REQ-001 The block SHALL have parameter DIV_W, default 26, width of the divisor and prescale counter.
REQ-002 The block SHALL have parameter CNT_W, default 16, width of the burst length and tick counter.
REQ-003 The block SHALL have parameter DIV_RESET, default 256, divisor value after reset.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 The block SHALL have port div_val, input, DIV_W, the new divisor, sampled when div_ld=1.
REQ-007 The block SHALL have port div_ld, input, 1, the divisor load strobe.
REQ-008 The block SHALL have port burst_len, input, CNT_W, the number of ticks per run, sampled with start.
REQ-009 The block SHALL have port start, input, 1, the run request.
REQ-010 The block SHALL have port stop, input, 1, the abort request.
REQ-011 The block SHALL have port tick, output, 1, a one-cycle clock-enable pulse for the datapath.
REQ-012 The block SHALL have port busy, output, 1, high while in RUN.
REQ-013 The block SHALL have port done, output, 1, a one-cycle pulse at burst completion.
REQ-014 The block SHALL have port tick_cnt, output, CNT_W, the ticks issued in the current or last run.

Function
REQ-015 The state machine SHALL have exactly three states: IDLE, RUN and DONE.
REQ-016 All outputs SHALL be registered, with no combinational path from any input to any output.
REQ-017 In IDLE, div_ld=1 SHALL load div_reg with div_val, and div_val=0 SHALL load 1.
REQ-018 When not in IDLE, div_ld SHALL be ignored.
REQ-019 In IDLE, start=1 SHALL capture burst_len, clear the prescale counter and tick_cnt, and enter RUN with busy=1 on the next cycle.
REQ-020 If div_ld and start are both high in the same IDLE cycle, the new divisor SHALL apply to that run.
REQ-021 start with burst_len=0 SHALL go IDLE->DONE directly, issue no tick, and pulse done exactly once.
REQ-022 In RUN, the prescale counter SHALL increment every cycle; on reaching div_reg-1 it SHALL wrap to 0, tick SHALL be high for the next cycle, and tick_cnt SHALL increment.
REQ-023 The first tick SHALL occur D cycles after the start-sample edge, and successive ticks SHALL be exactly D cycles apart, where D = div_reg.
REQ-024 With D=1, tick SHALL be high on every RUN cycle.
REQ-025 When the tick that makes tick_cnt equal the captured length is issued, the FSM SHALL enter DONE.
REQ-026 DONE SHALL last one cycle, with done=1 and busy=0, and the FSM SHALL then return to IDLE.
REQ-027 tick_cnt SHALL hold its final value until the next accepted start.
REQ-028 stop=1 in RUN SHALL return the FSM to IDLE on the next cycle with no done pulse.
REQ-029 stop SHALL take priority over a tick due in the same cycle, so that tick is not issued and tick_cnt does not increment.
REQ-030 start while in RUN or DONE SHALL be ignored and not queued.
REQ-031 stop in IDLE or DONE SHALL be ignored.
REQ-032 Neither tick_cnt nor the prescale counter SHALL wrap within a legal run.

Reset
REQ-033 rst_n=0 SHALL immediately force: state IDLE, tick=0, busy=0, done=0, tick_cnt=0, prescale counter=0, div_reg=DIV_RESET (0 treated as 1), captured length=0.
REQ-034 Reset during RUN SHALL abort the run with no done pulse.
REQ-035 Deassertion of rst_n SHALL take effect at the first clk edge after release.

Configuration
REQ-036 When macro TICK_SQUARE_OUT_EN is defined, the block SHALL add output clk_sq (1 bit, registered, reset 0) that toggles on every issued tick and holds its value outside RUN.
REQ-037 When TICK_SQUARE_OUT_EN is undefined, port clk_sq and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-038 Reset, then start with burst_len=3 and no div_ld -> ticks at 256, 512 and 768 cycles after start; done pulses once on the cycle after the third tick; tick_cnt=3.
REQ-039 div_ld with div_val=4, then start with burst_len=5 -> 5 ticks spaced 4 cycles apart; busy high for 20 cycles; done pulses once.
REQ-040 div_val=0 loaded, then start with burst_len=4 -> tick high on 4 consecutive cycles; done on the 5th.
REQ-041 start with burst_len=0 -> no tick; done pulses 1 cycle after the start-sample cycle; busy never asserts.
REQ-042 div=8, burst_len=10, stop asserted on the cycle the 3rd tick is due -> no 3rd tick, tick_cnt=2, no done; a start or div_ld issued mid-run is ignored.
REQ-043 rst_n pulsed low mid-run with div=8 -> outputs clear immediately and div_reg returns to 256; with TICK_SQUARE_OUT_EN defined and div=2, burst_len=4 -> clk_sq completes 2 full periods, ends at 0, and is forced to 0 by reset.
